axi4_lite_master: RTL

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_master_if.sv | 57 +++++
 rtl/axi4_lite_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes and the
// controller state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// Bundle of the CPU-side request/response channel and the AXI4-Lite master
// channels. "master" is the view of the bridge, "slave" the view of
// whatever sits around it (CPU plus AXI slave).
interface axi4_lite_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  // CPU request / response
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_W-1:0]     REQ_ADDR;
  logic [DATA_W-1:0]     REQ_WDATA;
  logic [DATA_W/8-1:0]   REQ_WSTRB;
  logic                  RSP_VALID;
  logic [DATA_W-1:0]     RSP_RDATA;
  logic                  RSP_ERR;

  // AXI4-Lite channels
  logic                  AW_VALID;
  logic                  AW_READY;
  logic [ADDR_W-1:0]     AW_ADDR;
  logic                  W_VALID;
  logic                  W_READY;
  logic [DATA_W-1:0]     W_DATA;
  logic [DATA_W/8-1:0]   W_STRB;
  logic                  B_VALID;
  logic                  B_READY;
  logic [1:0]            B_RESP;
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [ADDR_W-1:0]     AR_ADDR;
  logic                  R_VALID;
  logic                  R_READY;
  logic [DATA_W-1:0]     R_DATA;
  logic [1:0]            R_RESP;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
           AW_READY, W_READY, B_VALID, B_RESP, AR_READY,
           R_VALID, R_DATA, R_RESP,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
           AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
           AR_VALID, AR_ADDR, R_READY
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
           AW_READY, W_READY, B_VALID, B_RESP, AR_READY,
           R_VALID, R_DATA, R_RESP,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
           AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
           AR_VALID, AR_ADDR, R_READY
  );

endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a simple CPU request port.
// Optional build macro AXI_MASTER_ERR_CNT_EN adds a saturating ERR_CNT
// output counting error responses.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic               ACLK,
  input  logic               ARESTn,
  axi4_lite_master_if.master bus
`ifdef AXI_MASTER_ERR_CNT_EN
  ,
  output logic [7:0]         ERR_CNT
`endif
);

  // Clears the two byte-offset bits so every transfer is word aligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  aw_done, w_done;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  rsp_err_q;

  logic accept, aw_hs, w_hs, b_hs, r_hs;

  assign accept = bus.REQ_VALID && bus.REQ_READY;
  assign aw_hs  = bus.AW_VALID  && bus.AW_READY;
  assign w_hs   = bus.W_VALID   && bus.W_READY;
  assign b_hs   = bus.B_VALID   && bus.B_READY;
  assign r_hs   = bus.R_VALID   && bus.R_READY;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESTn) begin
    if (!ARESTn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and channel VALID/READY generation.
  always_comb begin
    // NOTE: every output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_nxt     = state;
    bus.REQ_READY = 1'b0;
    bus.AW_VALID  = 1'b0;
    bus.W_VALID   = 1'b0;
    bus.B_READY   = 1'b0;
    bus.AR_VALID  = 1'b0;
    bus.R_READY   = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the CPU sees not-ready while ARESTn is low.
        bus.REQ_READY = ARESTn;
        if (bus.REQ_VALID && ARESTn) state_nxt = bus.REQ_WE ? WR_REQ : RD_ADDR;
      end
      WR_REQ: begin
        bus.AW_VALID = !aw_done;
        bus.W_VALID  = !w_done;
        if ((aw_done || bus.AW_READY) && (w_done || bus.W_READY)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bus.B_READY = 1'b1;
        if (bus.B_VALID) state_nxt = IDLE;
      end
      RD_ADDR: begin
        bus.AR_VALID = 1'b1;
        if (bus.AR_READY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        bus.R_READY = 1'b1;
        if (bus.R_VALID) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, per-channel write completion and CPU response pulse.
  always_ff @(posedge ACLK or negedge ARESTn) begin
    if (!ARESTn) begin
      // NOTE: payload registers are reset too, so the AXI address/data
      // lines never show stale values from before reset.
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        addr_q  <= bus.REQ_ADDR;
        wdata_q <= bus.REQ_WDATA;
        wstrb_q <= bus.REQ_WSTRB;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_err_q   <= (bus.B_RESP != RESP_OKAY);
      end
      if (r_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= bus.R_DATA;
        rsp_err_q   <= (bus.R_RESP != RESP_OKAY);
      end
    end
  end

  assign bus.AW_ADDR   = addr_q & ALIGN_MASK;
  assign bus.AR_ADDR   = addr_q & ALIGN_MASK;
  assign bus.W_DATA    = wdata_q;
  assign bus.W_STRB    = wstrb_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;

`ifdef AXI_MASTER_ERR_CNT_EN
  // Saturating count of error responses delivered to the CPU.
  always_ff @(posedge ACLK or negedge ARESTn) begin
    if (!ARESTn)                                        ERR_CNT <= 8'd0;
    else if (rsp_valid_q && rsp_err_q && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
  end
`endif

endmodule
